// File: rtl/vram_arbiter_pkg.sv
// Shared text-VRAM geometry, fill character and engine state encodings.
// Cell layout is {attr[2:0], char[7:0]}.
package vram_arbiter_pkg;

  localparam int         COLS      = 40;
  localparam int         ROWS      = 30;
  localparam int         AW        = 11;
  localparam int         DW        = 11;
  localparam logic [7:0] FILL_CHAR = 8'h20;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FILL    = 3'd1;
  localparam logic [2:0] ST_SCRL_RD = 3'd2;
  localparam logic [2:0] ST_SCRL_WR = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  function automatic logic [10:0] make_cell(input logic [2:0] attr, input logic [7:0] ch);
    return {attr, ch};
  endfunction

endpackage

// File: rtl/vram_arbiter_fill_engine.sv
// Clear-screen fill engine; with VRAM_SCROLL_EN defined it also performs a
// one-row scroll-up (copy rows 1..29 up, then blank the last row).
module vram_arbiter_fill_engine
  import vram_arbiter_pkg::*;
#(
  parameter int         COLS      = 40,
  parameter int         ROWS      = 30,
  parameter int         AW        = 11,
  parameter int         DW        = 11,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_start,
  input  logic [2:0]    clr_attr,
  input  logic          scroll_start,
  input  logic          grant,
  input  logic [DW-1:0] rd_data,
  output logic          eng_req,
  output logic [AW-1:0] eng_addr,
  output logic          eng_we,
  output logic [DW-1:0] eng_wdata,
  output logic          eng_busy,
  output logic          eng_done
);

  localparam logic [AW-1:0] LAST_CELL = AW'(COLS * ROWS - 1);

  logic [2:0]    r_state;
  logic [AW-1:0] r_ptr;
  logic [2:0]    r_attr;

`ifdef VRAM_SCROLL_EN
  localparam logic [AW-1:0] LAST_SCRL = AW'(COLS * (ROWS - 1) - 1);
  localparam logic [AW-1:0] ROW_STEP  = AW'(COLS);

  logic [DW-1:0] r_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_hold <= '0;
    else if (r_state == ST_SCRL_RD && grant)
      r_hold <= rd_data;
  end
`else
  logic w_unused;
  assign w_unused = scroll_start ^ (^rd_data);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_attr  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Clear takes precedence over scroll when both are requested.
          if (clr_start) begin
            r_attr  <= clr_attr;
            r_ptr   <= '0;
            r_state <= ST_FILL;
          end
`ifdef VRAM_SCROLL_EN
          else if (scroll_start) begin
            r_attr  <= clr_attr;
            r_ptr   <= '0;
            r_state <= ST_SCRL_RD;
          end
`endif
        end
        ST_FILL: begin
          if (grant) begin
            if (r_ptr == LAST_CELL) r_state <= ST_DONE;
            else                    r_ptr   <= r_ptr + AW'(1);
          end
        end
`ifdef VRAM_SCROLL_EN
        ST_SCRL_RD: begin
          if (grant) r_state <= ST_SCRL_WR;
        end
        ST_SCRL_WR: begin
          // Leaving the copy phase with ptr at the start of the last row lets FILL blank it.
          if (grant) begin
            r_ptr   <= r_ptr + AW'(1);
            r_state <= (r_ptr == LAST_SCRL) ? ST_FILL : ST_SCRL_RD;
          end
        end
`endif
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    eng_req   = 1'b0;
    eng_addr  = r_ptr;
    eng_we    = 1'b0;
    eng_wdata = DW'(make_cell(r_attr, FILL_CHAR));
    case (r_state)
      ST_FILL: begin
        eng_req = 1'b1;
        eng_we  = 1'b1;
      end
`ifdef VRAM_SCROLL_EN
      ST_SCRL_RD: begin
        eng_req  = 1'b1;
        eng_addr = r_ptr + ROW_STEP;
      end
      ST_SCRL_WR: begin
        eng_req   = 1'b1;
        eng_we    = 1'b1;
        eng_wdata = r_hold;
      end
`endif
      default: ;
    endcase
  end

  assign eng_busy = (r_state == ST_FILL) || (r_state == ST_SCRL_RD) || (r_state == ST_SCRL_WR);
  assign eng_done = (r_state == ST_DONE);

endmodule

// File: rtl/vram_arbiter.sv
// Text-VRAM port arbiter: VGA fetch has absolute priority, CPU and the
// fill/scroll engine share the remaining slots round-robin. Optional: VRAM_SCROLL_EN.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int         COLS      = vram_arbiter_pkg::COLS,
  parameter int         ROWS      = vram_arbiter_pkg::ROWS,
  parameter int         AW        = vram_arbiter_pkg::AW,
  parameter int         DW        = vram_arbiter_pkg::DW,
  parameter logic [7:0] FILL_CHAR = vram_arbiter_pkg::FILL_CHAR
) (
  input  logic          vga_clk,
  input  logic          rst,
  input  logic          vga_rdn,
  input  logic [AW-1:0] vga_addr,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          clr_start,
  input  logic [2:0]    clr_attr,
  input  logic          scroll_start,
  output logic          eng_busy,
  output logic          eng_done,
  output logic [AW-1:0] vram_addr,
  output logic [DW-1:0] vram_din,
  output logic          vram_we,
  input  logic [DW-1:0] vram_dout
);

  logic          r_cpu_ack;
  logic [DW-1:0] r_cpu_rdata;
  logic          r_cpu_first;

  logic          w_cpu_elig;
  logic          w_cpu_gnt;
  logic          w_eng_gnt;
  logic          w_eng_req;
  logic [AW-1:0] w_eng_addr;
  logic          w_eng_we;
  logic [DW-1:0] w_eng_wdata;

  vram_arbiter_fill_engine #(
    .COLS(COLS), .ROWS(ROWS), .AW(AW), .DW(DW), .FILL_CHAR(FILL_CHAR)
  ) u_engine (
    .clk          (vga_clk),
    .rst_n        (rst),
    .clr_start    (clr_start),
    .clr_attr     (clr_attr),
    .scroll_start (scroll_start),
    .grant        (w_eng_gnt),
    .rd_data      (vram_dout),
    .eng_req      (w_eng_req),
    .eng_addr     (w_eng_addr),
    .eng_we       (w_eng_we),
    .eng_wdata    (w_eng_wdata),
    .eng_busy     (eng_busy),
    .eng_done     (eng_done)
  );

  // Blocking the CPU during its own ack cycle keeps a held request from being granted twice.
  assign w_cpu_elig = cpu_req && !r_cpu_ack;
  assign w_cpu_gnt  = vga_rdn && w_cpu_elig && (!w_eng_req || r_cpu_first);
  assign w_eng_gnt  = vga_rdn && w_eng_req  && (!w_cpu_elig || !r_cpu_first);

  always_comb begin
    vram_addr = vga_addr;
    vram_we   = 1'b0;
    vram_din  = cpu_wdata;
    if (w_cpu_gnt) begin
      vram_addr = cpu_addr;
      vram_we   = cpu_we;
    end else if (w_eng_gnt) begin
      vram_addr = w_eng_addr;
      vram_we   = w_eng_we;
      vram_din  = w_eng_wdata;
    end
    if (!rst) vram_we = 1'b0;
  end

  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      r_cpu_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_cpu_first <= 1'b1;
    end else begin
      r_cpu_ack <= w_cpu_gnt;
      if (w_cpu_gnt && !cpu_we) r_cpu_rdata <= vram_dout;
      if (w_cpu_gnt)      r_cpu_first <= 1'b0;
      else if (w_eng_gnt) r_cpu_first <= 1'b1;
    end
  end

  assign cpu_ack   = r_cpu_ack;
  assign cpu_rdata = r_cpu_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: CPU expectations are queued at issue
// and checked by a monitor on each cpu_ack; engine writes are tracked per cell.
module tb_vram_arbiter;

  logic        vga_clk;
  logic        rst;
  logic        vga_rdn;
  logic [10:0] vga_addr;
  logic        cpu_req;
  logic        cpu_we;
  logic [10:0] cpu_addr;
  logic [10:0] cpu_wdata;
  logic        cpu_ack;
  logic [10:0] cpu_rdata;
  logic        clr_start;
  logic [2:0]  clr_attr;
  logic        scroll_start;
  logic        eng_busy;
  logic        eng_done;
  logic [10:0] vram_addr;
  logic [10:0] vram_din;
  logic        vram_we;
  logic [10:0] vram_dout;

  vram_arbiter dut (
    .vga_clk(vga_clk), .rst(rst), .vga_rdn(vga_rdn), .vga_addr(vga_addr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .clr_start(clr_start), .clr_attr(clr_attr), .scroll_start(scroll_start),
    .eng_busy(eng_busy), .eng_done(eng_done),
    .vram_addr(vram_addr), .vram_din(vram_din), .vram_we(vram_we), .vram_dout(vram_dout)
  );

  typedef struct packed {
    logic        we;
    logic [10:0] addr;
    logic [10:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [10:0] mem [0:2047];
  int          hits [0:2047];
  int          base [0:1199];
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          errors = 0;
  int          checks = 0;

  initial begin
    vga_clk = 1'b0;
    forever #5 vga_clk = ~vga_clk;
  end

  // VRAM model: asynchronous read, synchronous write.
  assign vram_dout = mem[vram_addr];
  always @(posedge vga_clk) begin
    if (vram_we) begin
      mem[vram_addr]  <= vram_din;
      hits[vram_addr] <= hits[vram_addr] + 1;
      wr_cnt          <= wr_cnt + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge vga_clk) begin
    if (rst) begin
      if (eng_done) begin
        done_cnt++;
        chk("done_busy_low", int'(eng_busy), 0);
      end
      if (cpu_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cpu_ack_unexpected: got ack with empty scoreboard, expected none");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("cpu ack we=%0d addr=%0d data=0x%0h rdata=0x%0h", e.we, e.addr, e.data, cpu_rdata);
          if (e.we) chk("cpu_wr_mem", int'(mem[e.addr]), int'(e.data));
          else      chk("cpu_rd_data", int'(cpu_rdata), int'(e.data));
        end
      end
    end
  end

  task automatic cpu_issue(input logic we, input logic [10:0] a, input logic [10:0] d);
    exp_t e;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = we ? d : 11'h0;
    e.we = we;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic cpu_wait(output int cyc);
    cyc = 0;
    do begin
      @(posedge vga_clk);
      #1;
      cyc++;
    end while (!cpu_ack && cyc < 3000);
    if (!cpu_ack) chk("cpu_ack_timeout", 0, 1);
    cpu_req = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < limit) begin
      @(posedge vga_clk);
      #1;
      n++;
    end
    if (done_cnt == d0) chk("eng_done_timeout", 0, 1);
  endtask

  task automatic snap_hits();
    for (int a = 0; a < 1200; a++) base[a] = hits[a];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int bad;
    int w0;
    int d0;

    rst = 1'b0; vga_rdn = 1'b1; vga_addr = 11'd0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'd5; cpu_wdata = 11'h7FF;
    clr_start = 1'b0; clr_attr = 3'd0; scroll_start = 1'b0;

    // Reset state, with a CPU write pending to show vram_we is held low.
    repeat (2) @(posedge vga_clk);
    #1;
    chk("rst_cpu_ack", int'(cpu_ack), 0);
    chk("rst_cpu_rdata", int'(cpu_rdata), 0);
    chk("rst_eng_busy", int'(eng_busy), 0);
    chk("rst_eng_done", int'(eng_done), 0);
    chk("rst_vram_we", int'(vram_we), 0);
    cpu_req = 1'b0;
    @(negedge vga_clk) rst = 1'b1;
    @(posedge vga_clk); #1;

    // CPU write then read back.
    cpu_issue(1'b1, 11'd12, 11'h541);
    cpu_wait(c);
    chk("cpu_wr_latency", c, 1);
    @(posedge vga_clk); #1;
    cpu_issue(1'b0, 11'd12, 11'h541);
    cpu_wait(c);
    chk("cpu_rd_latency", c, 1);
    repeat (3) @(posedge vga_clk);
    #1;
    chk("cpu_rdata_hold", int'(cpu_rdata), 11'h541);

    // VGA priority.
    vga_rdn = 1'b0; vga_addr = 11'd33;
    cpu_issue(1'b0, 11'd12, 11'h541);
    for (int i = 0; i < 3; i++) begin
      @(posedge vga_clk); #1;
      chk("vga_blocks_ack", int'(cpu_ack), 0);
      chk("vga_vram_we", int'(vram_we), 0);
      chk("vga_vram_addr", int'(vram_addr), 33);
    end
    vga_rdn = 1'b1;
    @(posedge vga_clk); #1;
    chk("vga_release_ack", int'(cpu_ack), 1);
    cpu_req = 1'b0;
    @(posedge vga_clk); #1;

    // Clear screen, no other traffic.
    snap_hits();
    w0 = wr_cnt;
    d0 = done_cnt;
    clr_attr = 3'b010; clr_start = 1'b1;
    @(posedge vga_clk); #1;
    clr_start = 1'b0;
    chk("clr_busy_high", int'(eng_busy), 1);
    wait_done(3000);
    repeat (2) @(posedge vga_clk);
    #1;
    chk("clr_busy_after", int'(eng_busy), 0);
    chk("clr_done_once", done_cnt - d0, 1);
    chk("clr_write_count", wr_cnt - w0, 1200);
    bad = 0;
    for (int a = 0; a < 1200; a++)
      if (mem[a] !== 11'h220 || hits[a] - base[a] != 1) bad++;
    chk("clr_cells_bad", bad, 0);

    // Contention: CPU writes while the clear runs.
    @(posedge vga_clk); #1;
    cpu_issue(1'b1, 11'd1300, 11'h100);
    cpu_wait(c);
    chk("idle_cpu_latency", c, 1);
    snap_hits();
    w0 = wr_cnt;
    d0 = done_cnt;
    cpu_issue(1'b1, 11'd1301, 11'h101);
    clr_attr = 3'b101; clr_start = 1'b1;
    @(posedge vga_clk); #1;
    clr_start = 1'b0;
    chk("cont_ack_blocked", int'(cpu_ack), 0);
    cpu_wait(c);
    chk("cont_engine_first", c, 2);
    for (int i = 2; i < 10; i++) begin
      cpu_issue(1'b1, 11'(1300 + i), 11'(11'h100 + i));
      cpu_wait(c);
      chk("cont_alt_latency", c, 2);
    end
    wait_done(3000);
    repeat (2) @(posedge vga_clk);
    #1;
    chk("cont_done_once", done_cnt - d0, 1);
    chk("cont_write_count", wr_cnt - w0, 1209);
    bad = 0;
    for (int a = 0; a < 1200; a++)
      if (mem[a] !== 11'h520 || hits[a] - base[a] != 1) bad++;
    chk("cont_cells_bad", bad, 0);

    // Reset in the middle of a clear.
    clr_attr = 3'b111; clr_start = 1'b1;
    @(posedge vga_clk); #1;
    clr_start = 1'b0;
    c = 0;
    do begin
      @(negedge vga_clk);
      c++;
    end while (!(vram_we && vram_addr == 11'd500) && c < 2000);
    chk("midrst_reach_500", int'(vram_we && vram_addr == 11'd500), 1);
    rst = 1'b0;
    #1;
    chk("midrst_vram_we", int'(vram_we), 0);
    chk("midrst_busy", int'(eng_busy), 0);
    chk("midrst_rdata", int'(cpu_rdata), 0);
    chk("midrst_ack", int'(cpu_ack), 0);
    @(negedge vga_clk) rst = 1'b1;
    w0 = wr_cnt;
    repeat (50) @(posedge vga_clk);
    #1;
    chk("midrst_no_writes", wr_cnt - w0, 0);
    chk("midrst_busy_after", int'(eng_busy), 0);
    bad = 0;
    for (int a = 0; a < 500; a++) if (mem[a] !== 11'h720) bad++;
    for (int a = 500; a < 1200; a++) if (mem[a] !== 11'h520) bad++;
    chk("midrst_cells_bad", bad, 0);

`ifdef VRAM_SCROLL_EN
    // Scroll up one row.
    cpu_issue(1'b1, 11'd40, 11'h141);
    cpu_wait(c);
    @(posedge vga_clk); #1;
    d0 = done_cnt;
    clr_attr = 3'b011; scroll_start = 1'b1;
    @(posedge vga_clk); #1;
    scroll_start = 1'b0;
    chk("scrl_busy_high", int'(eng_busy), 1);
    wait_done(5000);
    repeat (2) @(posedge vga_clk);
    #1;
    chk("scrl_done_once", done_cnt - d0, 1);
    chk("scrl_cell0", int'(mem[0]), 11'h141);
    chk("scrl_cell1159", int'(mem[1159]), 11'h520);
    bad = 0;
    for (int a = 1160; a < 1200; a++) if (mem[a] !== 11'h320) bad++;
    chk("scrl_last_row_bad", bad, 0);
`else
    // Without the scroll option, scroll_start does nothing.
    w0 = wr_cnt;
    scroll_start = 1'b1;
    @(posedge vga_clk); #1;
    scroll_start = 1'b0;
    chk("scrl_ignored_busy", int'(eng_busy), 0);
    repeat (20) @(posedge vga_clk);
    #1;
    chk("scrl_ignored_writes", wr_cnt - w0, 0);
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
